// File: rtl/ps2_cmd_arbiter.sv
// Round-robin owner of the shared PS/2 transmitter for keyboard and mouse
// command requests.
//
// Ports:
//   CLOCK_50              system clock, rising edge
//   KEY                   asynchronous active-high reset
//   kb_req/kb_cmd         keyboard request level and command byte
//   kb_done/kb_err        keyboard completion pulses
//   ms_req/ms_cmd         mouse request level and command byte
//   ms_done/ms_err        mouse completion pulses
//   tx_start/tx_data      transmitter kick pulse and byte
//   tx_busy/tx_error      transmitter status
//   rx_valid/rx_data      received byte stream from the device
//   rx_pass               high when received bytes may reach the decoders
//   grant                 one-hot owner, bit0 keyboard, bit1 mouse
module ps2_cmd_arbiter #(
    parameter int ACK_TIMEOUT = 2500000,
    parameter int MAX_RETRY   = 2
) (
    input  logic       CLOCK_50,
    input  logic       KEY,
    input  logic       kb_req,
    input  logic [7:0] kb_cmd,
    output logic       kb_done,
    output logic       kb_err,
    input  logic       ms_req,
    input  logic [7:0] ms_cmd,
    output logic       ms_done,
    output logic       ms_err,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_error,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_pass,
    output logic [1:0] grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_WAIT_ACK,
        S_RESP
    } state_t;

    localparam logic [21:0] TO_LAST = 22'(ACK_TIMEOUT - 1);
    localparam logic [1:0]  RMAX    = 2'(MAX_RETRY);

    state_t      state, state_nx;
    logic [7:0]  cmd_q, cmd_nx;
    logic [1:0]  grant_q, grant_nx;
    logic [1:0]  retry_q, retry_nx;
    logic [21:0] cnt_q, cnt_nx;
    logic        first_q, first_nx;
    logic        last_ms_q, last_ms_nx;
    logic        done_nx, err_nx, fail;
    logic        pick_ms;
    logic        kb_done_q, kb_err_q, ms_done_q, ms_err_q;

    // Tie goes to whoever did not win last time.
    assign pick_ms = ms_req & (~kb_req | ~last_ms_q);

    always_comb begin
        state_nx   = state;
        cmd_nx     = cmd_q;
        grant_nx   = grant_q;
        retry_nx   = retry_q;
        cnt_nx     = cnt_q;
        first_nx   = first_q;
        last_ms_nx = last_ms_q;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        fail       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (kb_req || ms_req) begin
                    grant_nx   = pick_ms ? 2'b10 : 2'b01;
                    cmd_nx     = pick_ms ? ms_cmd : kb_cmd;
                    last_ms_nx = pick_ms;
                    retry_nx   = 2'd0;
                    state_nx   = S_SEND;
                end
            end
            S_SEND: begin
                first_nx = 1'b1;
                state_nx = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // busy only rises the cycle after tx_start, so the
                // first cycle here cannot be trusted
                first_nx = 1'b0;
                if (tx_error) begin
                    fail = 1'b1;
                end else if (!first_q && !tx_busy) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (cnt_q != '1) begin
                    cnt_nx = cnt_q + 22'd1;
                end
                // a received byte outranks a timeout in the same cycle
                if (rx_valid) begin
                    unique case (rx_data)
                        8'hFA:   done_nx = 1'b1;
                        8'hFE:   fail    = 1'b1;
                        8'hFC:   err_nx  = 1'b1;
                        default: ;
                    endcase
                end else if (cnt_q >= TO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (fail) begin
            if (retry_q < RMAX) begin
                retry_nx = retry_q + 2'd1;
                state_nx = S_SEND;
            end else begin
                err_nx = 1'b1;
            end
        end

        if (done_nx || err_nx) begin
            grant_nx = 2'b00;
            state_nx = S_RESP;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge KEY) begin
        if (KEY) begin
            state     <= S_IDLE;
            cmd_q     <= 8'h00;
            grant_q   <= 2'b00;
            retry_q   <= 2'd0;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            last_ms_q <= 1'b1;
            kb_done_q <= 1'b0;
            kb_err_q  <= 1'b0;
            ms_done_q <= 1'b0;
            ms_err_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_q     <= cmd_nx;
            grant_q   <= grant_nx;
            retry_q   <= retry_nx;
            cnt_q     <= cnt_nx;
            first_q   <= first_nx;
            last_ms_q <= last_ms_nx;
            // owner is still in grant_q on the terminating cycle
            kb_done_q <= done_nx & grant_q[0];
            kb_err_q  <= err_nx  & grant_q[0];
            ms_done_q <= done_nx & grant_q[1];
            ms_err_q  <= err_nx  & grant_q[1];
        end
    end

    assign tx_start = (state == S_SEND);
    assign tx_data  = cmd_q;
    assign grant    = grant_q;
    assign rx_pass  = (state != S_WAIT_TX) && (state != S_WAIT_ACK);
    assign kb_done  = kb_done_q;
    assign kb_err   = kb_err_q;
    assign ms_done  = ms_done_q;
    assign ms_err   = ms_err_q;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Bench for ps2_cmd_arbiter: a transaction-level expectation process plus
// a per-cycle compare, and directed device/transmitter scenarios.
module tb_ps2_cmd_arbiter;

    localparam int TO  = 100;
    localparam int MR  = 2;
    localparam int PER = 10;

    logic       clk = 1'b0;
    logic       KEY = 1'b1;
    logic       kb_req = 1'b0, ms_req = 1'b0;
    logic [7:0] kb_cmd = 8'h00, ms_cmd = 8'h00;
    logic       kb_done, kb_err, ms_done, ms_err;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0, tx_error = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_pass;
    logic [1:0] grant;

    ps2_cmd_arbiter #(.ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .CLOCK_50(clk), .KEY(KEY),
        .kb_req(kb_req), .kb_cmd(kb_cmd),
        .kb_done(kb_done), .kb_err(kb_err),
        .ms_req(ms_req), .ms_cmd(ms_cmd),
        .ms_done(ms_done), .ms_err(ms_err),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_error(tx_error),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_pass(rx_pass), .grant(grant)
    );

    always #(PER/2) clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- expectation model ----------------
    logic [1:0] e_grant;
    logic [7:0] e_data;
    logic       e_start, e_pass, e_kbd, e_kbe, e_msd, e_mse;
    bit         m_rst;
    bit         m_last_ms;

    task automatic m_reset();
        e_grant = 2'b00; e_data = 8'h00; e_start = 1'b0; e_pass = 1'b1;
        e_kbd = 0; e_kbe = 0; e_msd = 0; e_mse = 0;
        m_last_ms = 1'b1; m_rst = 1'b0;
    endtask

    // advance to the next cycle; inputs read afterwards are the ones
    // the device saw on the edge just taken
    task automatic m_tick();
        @(posedge clk);
        e_start = 0; e_kbd = 0; e_kbe = 0; e_msd = 0; e_mse = 0;
        if (KEY) m_rst = 1'b1;
    endtask

    // one whole command, from the first send cycle to the idle cycle after
    task automatic m_txn(input bit ms);
        int tries, waited, res;
        bit first;
        tries = 0;
        e_grant = ms ? 2'b10 : 2'b01;
        e_data  = ms ? ms_cmd : kb_cmd;
        forever begin
            e_start = 1; e_pass = 1;
            m_tick(); if (m_rst) return;
            e_pass = 0;
            res = 0; first = 1;
            forever begin
                m_tick(); if (m_rst) return;
                if (tx_error) begin res = 1; break; end
                if (!first && !tx_busy) break;
                first = 0;
            end
            if (res == 0) begin
                waited = 0;
                forever begin
                    m_tick(); if (m_rst) return;
                    if (rx_valid) begin
                        if (rx_data == 8'hFA) res = 2;
                        else if (rx_data == 8'hFC) res = 3;
                        else if (rx_data == 8'hFE) res = 1;
                    end else if (waited >= TO - 1) begin
                        res = 1;
                    end
                    if (res != 0) break;
                    waited++;
                end
            end
            if (res == 1) begin
                if (tries < MR) begin tries++; continue; end
                res = 3;
            end
            e_grant = 2'b00; e_pass = 1;
            e_kbd = !ms && res == 2; e_kbe = !ms && res == 3;
            e_msd =  ms && res == 2; e_mse =  ms && res == 3;
            m_tick();
            return;
        end
    endtask

    initial begin
        bit pick;
        m_reset();
        forever begin
            m_tick();
            if (m_rst) begin m_reset(); continue; end
            if (kb_req || ms_req) begin
                pick = ms_req && (!kb_req || !m_last_ms);
                m_last_ms = pick;
                m_txn(pick);
                if (m_rst) m_reset();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_on = 0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("grant",    grant,    e_grant);
            chk("tx_start", tx_start, e_start);
            chk("tx_data",  tx_data,  e_data);
            chk("rx_pass",  rx_pass,  e_pass);
            chk("kb_done",  kb_done,  e_kbd);
            chk("kb_err",   kb_err,   e_kbe);
            chk("ms_done",  ms_done,  e_msd);
            chk("ms_err",   ms_err,   e_mse);
        end
    end

    // ---------------- event counters ----------------
    int n_start = 0, n_kbd = 0, n_kbe = 0, n_msd = 0, n_mse = 0;
    int n_fwd = 0;
    always @(negedge clk) begin
        if (tx_start) n_start++;
        if (kb_done)  n_kbd++;
        if (kb_err)   n_kbe++;
        if (ms_done)  n_msd++;
        if (ms_err)   n_mse++;
    end
    always @(posedge clk) begin
        if (rx_valid && rx_pass) n_fwd++;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] sent[$];
    time t_fall;
    bit  gap_armed = 0;
    int  s_start, s_kbd, s_kbe, s_msd, s_mse, s_fwd;

    // requesters drop req as soon as they see their done/err
    task automatic nclk();
        @(negedge clk);
        if (kb_done || kb_err) kb_req = 1'b0;
        if (ms_done || ms_err) ms_req = 1'b0;
    endtask

    task automatic snap();
        sent.delete();
        gap_armed = 0;
        s_start = n_start; s_kbd = n_kbd; s_kbe = n_kbe;
        s_msd = n_msd; s_mse = n_mse; s_fwd = n_fwd;
    endtask

    task automatic tally(input string t, input int st, input int kd,
                         input int ke, input int md, input int me);
        chk({t, "_starts"}, n_start - s_start, st);
        chk({t, "_kb_done"}, n_kbd - s_kbd, kd);
        chk({t, "_kb_err"}, n_kbe - s_kbe, ke);
        chk({t, "_ms_done"}, n_msd - s_msd, md);
        chk({t, "_ms_err"}, n_mse - s_mse, me);
    endtask

    // transmitter and device side of one send attempt
    task automatic attempt(input int busy_n, input bit txerr,
                           input bit has_rsp, input logic [7:0] rsp,
                           input bit stray);
        int k;
        k = 0;
        while (!tx_start && k < 400) begin nclk(); k++; end
        chk("tx_start_seen", tx_start, 1'b1);
        if (!tx_start) return;
        if (gap_armed) begin
            chk("retry_gap", 32'(($time - t_fall) / PER), TO);
            gap_armed = 0;
        end
        sent.push_back(tx_data);
        nclk(); tx_busy = 1'b1;
        repeat (busy_n) nclk();
        tx_busy = 1'b0; tx_error = txerr;
        nclk(); tx_error = 1'b0;
        if (txerr) return;
        t_fall = $time;
        if (stray) begin
            rx_valid = 1'b1; rx_data = 8'h08;
            nclk(); rx_valid = 1'b0;
        end
        if (has_rsp) begin
            nclk(); rx_valid = 1'b1; rx_data = rsp;
            nclk(); rx_valid = 1'b0;
        end else begin
            gap_armed = 1;
        end
    endtask

    task automatic wait_free(input int n);
        int k;
        k = 0;
        while ((kb_req || ms_req) && k < n) begin nclk(); k++; end
        chk("req_released", {30'd0, kb_req, ms_req}, 0);
        repeat (3) nclk();
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        @(posedge clk);
        cmp_on = 1;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_pass", rx_pass, 1'b1);
        KEY = 1'b0;
        repeat (2) nclk();

        // tie right after reset: keyboard then mouse
        snap();
        kb_cmd = 8'hED; ms_cmd = 8'hF4;
        kb_req = 1; ms_req = 1;
        attempt(5, 0, 1, 8'hFA, 0);
        attempt(5, 0, 1, 8'hFA, 0);
        wait_free(50);
        chk("tie1_n", sent.size(), 2);
        chk("tie1_first", sent[0], 8'hED);
        chk("tie1_second", sent[1], 8'hF4);
        tally("tie1", 2, 1, 0, 1, 0);

        // single keyboard LED command, long transmit
        snap();
        kb_req = 1;
        attempt(20, 0, 1, 8'hFA, 0);
        wait_free(50);
        chk("kb_single_data", sent[0], 8'hED);
        tally("kb_single", 1, 1, 0, 0, 0);

        // keyboard won last, so the next tie goes to the mouse
        snap();
        kb_req = 1; ms_req = 1;
        attempt(4, 0, 1, 8'hFA, 0);
        attempt(4, 0, 1, 8'hFA, 0);
        wait_free(50);
        chk("tie2_first", sent[0], 8'hF4);
        chk("tie2_second", sent[1], 8'hED);
        tally("tie2", 2, 1, 0, 1, 0);

        // resend requested every time: three sends, then error
        snap();
        ms_req = 1;
        repeat (3) attempt(6, 0, 1, 8'hFE, 0);
        wait_free(50);
        chk("resend_d0", sent[0], 8'hF4);
        chk("resend_d1", sent[1], 8'hF4);
        chk("resend_d2", sent[2], 8'hF4);
        tally("resend", 3, 0, 0, 0, 1);

        // silent device with a stray byte during the first wait
        snap();
        ms_req = 1;
        attempt(10, 0, 0, 8'h00, 1);
        attempt(10, 0, 0, 8'h00, 0);
        attempt(10, 0, 0, 8'h00, 0);
        wait_free(300);
        chk("timeout_fwd", n_fwd - s_fwd, 0);
        tally("timeout", 3, 0, 0, 0, 1);

        // bytes seen while idle are forwarded
        snap();
        rx_valid = 1; rx_data = 8'hAA;
        nclk(); rx_valid = 0;
        nclk();
        chk("idle_fwd", n_fwd - s_fwd, 1);

        // transmitter fault on the first attempt
        snap();
        kb_req = 1;
        attempt(8, 1, 0, 8'h00, 0);
        attempt(8, 0, 1, 8'hFA, 0);
        wait_free(50);
        tally("txerr", 2, 1, 0, 0, 0);

        // device reports error
        snap();
        kb_req = 1;
        attempt(3, 0, 1, 8'hFC, 0);
        wait_free(50);
        tally("devfail", 1, 0, 1, 0, 0);

        // reset while waiting for the acknowledge
        snap();
        kb_cmd = 8'hF3; kb_req = 1;
        attempt(5, 0, 0, 8'h00, 0);
        gap_armed = 0;
        repeat (2) nclk();
        chk("pre_key_rx_pass", rx_pass, 1'b0);
        #1 KEY = 1'b1;
        #1;
        chk("key_grant", grant, 2'b00);
        chk("key_tx_data", tx_data, 8'h00);
        chk("key_rx_pass", rx_pass, 1'b1);
        repeat (2) nclk();
        KEY = 1'b0;
        attempt(5, 0, 1, 8'hFA, 0);
        wait_free(50);
        chk("key_regrant_data", sent[1], 8'hF3);
        tally("key", 2, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
